pattern_merge_sched: RTL

//  Round-robin scheduler that shares one merged-pattern evaluation datapath between NREQ requesters.
//  The datapath is a flop-terminated combinational netlist with fixed latency LAT.
//  - Accepts one request vector per cycle and issues it to the datapath.
//  - Tracks in-flight tags and routes each result back to the issuing requester.
//  - Supports a flush/halt sequence so the datapath can be quiesced and swapped.

---
 rtl/pattern_merge_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pattern_merge_sched.sv
// ============================================================================
// Module   : pattern_merge_sched
// Brief    : Round-robin scheduler sharing one fixed-latency merged-pattern
//            datapath among NREQ requesters, with flush/halt quiescing.
//            Optional: PATTERN_SCHED_PRIO_EN gives requester 0 fixed priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_merge_sched #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 11,
    parameter int OUT_W = 8,
    parameter int LAT   = 2
) (
    input  logic                        blif_clk_net,
    input  logic                        blif_reset_net,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*IN_W-1:0]        req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        dp_in_valid,
    output logic [IN_W-1:0]             dp_in_data,
    input  logic                        dp_out_valid,
    input  logic [OUT_W-1:0]            dp_out_data,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [OUT_W-1:0]            rsp_data,
    input  logic                        flush_req,
    input  logic                        resume,
    output logic                        flush_done,
    output logic [$clog2(LAT+2):0]      inflight,
    output logic                        err_sticky
);

    localparam int TAG_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(LAT+2) + 1;
`ifdef PATTERN_SCHED_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [TAG_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]       grant_idx;
    logic [TAG_W-1:0]       scan_idx;
    logic                   grant_hit;
    logic                   fire;

    logic [LAT:0]           tag_v_q;
    logic [TAG_W-1:0]       tag_q [0:LAT];

    logic                   dp_in_valid_q;
    logic [IN_W-1:0]        dp_in_data_q;
    logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [OUT_W-1:0]       rsp_data_q;
    logic                   err_q;
    logic [CNT_W-1:0]       inflight_q;
    logic                   rsp_any;

    // Arbitration: scan upward from rr_ptr; with priority enabled requester 0
    // is checked first and excluded from the rotating scan.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        req_ready = '0;
        rr_ptr_d  = rr_ptr_q;
        if (state_q == ST_RUN) begin
            if (PRIO && req_valid[0]) begin
                grant_hit = 1'b1;
                grant_idx = '0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    scan_idx = rr_ptr_q + TAG_W'(i);
                    if (!grant_hit && !(PRIO && scan_idx == '0) && req_valid[scan_idx]) begin
                        grant_hit = 1'b1;
                        grant_idx = scan_idx;
                    end
                end
            end
        end
        if (grant_hit) begin
            req_ready[grant_idx] = 1'b1;
        end
        fire = grant_hit && req_valid[grant_idx];
        if (fire && !(PRIO && grant_idx == '0)) begin
            rr_ptr_d = grant_idx + TAG_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (inflight_q == '0 && tag_v_q == '0) begin
                    state_d    = ST_HALT;
                    flush_done = 1'b1;
                end
            end
            ST_HALT: begin
                if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Oldest tag stage lines up with dp_out_valid; any disagreement is an error.
    always_comb begin
        rsp_valid_d = '0;
        if (dp_out_valid && tag_v_q[LAT]) begin
            rsp_valid_d[tag_q[LAT]] = 1'b1;
        end
    end

    assign rsp_any = |rsp_valid_q;

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            state_q       <= ST_RUN;
            rr_ptr_q      <= '0;
            tag_v_q       <= '0;
            for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
            dp_in_valid_q <= 1'b0;
            dp_in_data_q  <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            err_q         <= 1'b0;
            inflight_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            tag_v_q       <= {tag_v_q[LAT-1:0], fire};
            tag_q[0]      <= grant_idx;
            for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
            dp_in_valid_q <= fire;
            if (fire) begin
                dp_in_data_q <= req_data[int'(grant_idx)*IN_W +: IN_W];
            end
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= dp_out_data;
            err_q         <= err_q | (dp_out_valid ^ tag_v_q[LAT]);
            if (fire && !rsp_any) begin
                inflight_q <= inflight_q + CNT_W'(1);
            end else if (!fire && rsp_any) begin
                inflight_q <= inflight_q - CNT_W'(1);
            end
        end
    end

    assign dp_in_valid = dp_in_valid_q;
    assign dp_in_data  = dp_in_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign err_sticky  = err_q;
    assign inflight    = inflight_q;

endmodule

`default_nettype wire
